// File: rtl/ob_cmd_deframer.sv
// ob_cmd_deframer: turns the host-link byte stream into order-book commands.
// Frame: SOF, opcode, uid, quantity, price (multi-byte fields MSB first), XOR checksum
// over the bytes between SOF and the checksum. Bad or stalled frames are dropped and counted.
// Command layout on cmd_r (MSB to LSB): {opcode, uid, quantity, price}. The quantity/price
// pair is the buy view of the operand; the sell view aliases the same bits.
module ob_cmd_deframer #(
    parameter logic [7:0]  SOF         = 8'hA5,
    parameter int unsigned UID_B       = 4,
    parameter int unsigned QTY_B       = 2,
    parameter int unsigned PRICE_B     = 2,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned ERR_CNT_W   = 16,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned UID_W       = 32,
    parameter int unsigned QTY_W       = 16,
    parameter int unsigned PRICE_W     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_vld,
    input  logic [7:0]                            in_data,
    output logic                                  in_rdy,
    input  logic                                  cmd_full_r,
    output logic                                  cmd_vld_r,
    output logic [OP_W+UID_W+QTY_W+PRICE_W-1:0]   cmd_r,
    output logic                                  err_csum_r,
    output logic                                  err_tmo_r,
    output logic [ERR_CNT_W-1:0]                  err_cnt_r
);

    localparam int unsigned BODY_B     = 1 + UID_B + QTY_B + PRICE_B;
    localparam int unsigned IDX_W      = $clog2(BODY_B + 1);
    localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned UID_BITS   = 8 * UID_B;
    localparam int unsigned QTY_BITS   = 8 * QTY_B;
    localparam int unsigned PRICE_BITS = 8 * PRICE_B;
    localparam int unsigned CMD_W      = OP_W + UID_W + QTY_W + PRICE_W;

    typedef enum logic [1:0] {StHunt, StBody, StCsum, StPushWait} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              xor_q, xor_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [7:0]              op_q, op_d;
    logic [UID_BITS-1:0]     uid_q, uid_d;
    logic [QTY_BITS-1:0]     qty_q, qty_d;
    logic [PRICE_BITS-1:0]   price_q, price_d;
    logic                    cmd_vld_d, err_csum_d, err_tmo_d;
    logic [CMD_W-1:0]        cmd_d, cmd_asm;
    logic [ERR_CNT_W-1:0]    err_cnt_d;
    logic                    accept, drop, idle_tick;

    // Assembled command from the captured fields, resized to the command field widths.
    always_comb begin
        cmd_asm = {OP_W'(op_q), UID_W'(uid_q), QTY_W'(qty_q), PRICE_W'(price_q)};
    end

    // Next-state, field capture, timeout and error accounting.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        tmo_d      = tmo_q;
        op_d       = op_q;
        uid_d      = uid_q;
        qty_d      = qty_q;
        price_d    = price_q;
        cmd_vld_d  = 1'b0;
        err_csum_d = 1'b0;
        err_tmo_d  = 1'b0;
        cmd_d      = cmd_r;
        err_cnt_d  = err_cnt_r;
        drop       = 1'b0;
        idle_tick  = 1'b0;

        in_rdy = (state_q != StPushWait);
        accept = in_vld & in_rdy;

        unique case (state_q)
            StHunt: begin
                if (accept && in_data == SOF) begin
                    state_d = StBody;
                    idx_d   = '0;
                    xor_d   = '0;
                    tmo_d   = '0;
                end
            end
            StBody: begin
                if (accept) begin
                    xor_d = xor_q ^ in_data;
                    tmo_d = '0;
                    if (idx_q == '0) begin
                        op_d = in_data;
                    end else if (idx_q <= IDX_W'(UID_B)) begin
                        uid_d = (uid_q << 8) | UID_BITS'(in_data);
                    end else if (idx_q <= IDX_W'(UID_B + QTY_B)) begin
                        qty_d = (qty_q << 8) | QTY_BITS'(in_data);
                    end else begin
                        price_d = (price_q << 8) | PRICE_BITS'(in_data);
                    end
                    if (idx_q == IDX_W'(BODY_B - 1)) begin
                        state_d = StCsum;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    idle_tick = 1'b1;
                end
            end
            StCsum: begin
                if (accept) begin
                    tmo_d = '0;
                    if (in_data != xor_q) begin
                        err_csum_d = 1'b1;
                        drop       = 1'b1;
                        state_d    = StHunt;
                    end else if (cmd_full_r) begin
                        state_d = StPushWait;
                    end else begin
                        cmd_vld_d = 1'b1;
                        cmd_d     = cmd_asm;
                        state_d   = StHunt;
                    end
                end else begin
                    idle_tick = 1'b1;
                end
            end
            StPushWait: begin
                if (!cmd_full_r) begin
                    cmd_vld_d = 1'b1;
                    cmd_d     = cmd_asm;
                    state_d   = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase

        // An accepted byte always clears the idle count, so it wins over the timeout.
        if (idle_tick) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                err_tmo_d = 1'b1;
                drop      = 1'b1;
                state_d   = StHunt;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        if (drop && err_cnt_r != '1) begin
            err_cnt_d = err_cnt_r + 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StHunt;
            idx_q      <= '0;
            xor_q      <= '0;
            tmo_q      <= '0;
            op_q       <= '0;
            uid_q      <= '0;
            qty_q      <= '0;
            price_q    <= '0;
            cmd_vld_r  <= 1'b0;
            cmd_r      <= '0;
            err_csum_r <= 1'b0;
            err_tmo_r  <= 1'b0;
            err_cnt_r  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            tmo_q      <= tmo_d;
            op_q       <= op_d;
            uid_q      <= uid_d;
            qty_q      <= qty_d;
            price_q    <= price_d;
            cmd_vld_r  <= cmd_vld_d;
            cmd_r      <= cmd_d;
            err_csum_r <= err_csum_d;
            err_tmo_r  <= err_tmo_d;
            err_cnt_r  <= err_cnt_d;
        end
    end

endmodule
